// File: rtl/alu_pkg.sv
// Shared opcode map, word widths, sequencer states and an opcode-class helper.
package alu_pkg;

  localparam int unsigned OPC_W      = 4;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned INSTR_W    = OPC_W + DATA_W_DEF;

  // ALU opcodes 0x0..0xC are issued to the decoder; 0xD..0xF never leave the sequencer.
  localparam logic [3:0] OP_WR_PRI   = 4'h0;
  localparam logic [3:0] OP_PRI_PASS = 4'hC;
  localparam logic [3:0] OP_REPEAT   = 4'hD;
  localparam logic [3:0] OP_HALT     = 4'hE;
  localparam logic [3:0] OP_NOP      = 4'hF;

  // Pass-through opcode performs no register writes, so it is safe to present when idle.
  localparam logic [3:0] IDLE_OPCODE = OP_PRI_PASS;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRepeat
  } seq_state_e;

  function automatic logic is_issuable(logic [3:0] op);
    return op <= OP_PRI_PASS;
  endfunction

endpackage

// File: rtl/alu_instruction_sequencer_if.sv
// Instruction handshake in, ALU opcode/operand out.
interface alu_instruction_sequencer_if #(
  parameter int unsigned DATA_W = 16
);

  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [3:0]        instr_opcode_i;
  logic [DATA_W-1:0] instr_operand_i;
  logic [3:0]        alu_opcode_o;
  logic [DATA_W-1:0] alu_operand_o;
  logic              alu_en_o;

  // Sequencer side.
  modport slave (
    input  instr_valid_i,
    input  instr_opcode_i,
    input  instr_operand_i,
    output instr_ready_o,
    output alu_opcode_o,
    output alu_operand_o,
    output alu_en_o
  );

  // Instruction producer / ALU consumer side.
  modport master (
    output instr_valid_i,
    output instr_opcode_i,
    output instr_operand_i,
    input  instr_ready_o,
    input  alu_opcode_o,
    input  alu_operand_o,
    input  alu_en_o
  );

endinterface

// File: rtl/instr_fifo.sv
// Instruction word FIFO with registered level and synchronous clear.
// Callers must not push when full nor pop when empty.
module instr_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 20
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset; the level alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/alu_instruction_sequencer.sv
// Buffers instruction words and issues one ALU opcode/operand per cycle, handling
// the sequencer-only REPEAT, HALT and NOP opcodes locally.
module alu_instruction_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REP_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  alu_instruction_sequencer_if.slave bus,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [$clog2(DEPTH):0]    fifo_level_o
);

  localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
  localparam int unsigned InstrW = OPC_W + DATA_W;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  seq_state_e state_q, state_d;

  logic              push, pop, fifo_empty;
  logic [InstrW-1:0] rd_word;
  logic [LvlW-1:0]   level;
  logic [3:0]        pop_op;
  logic [DATA_W-1:0] pop_operand;

  logic              issue;
  logic [3:0]        iss_op;
  logic [DATA_W-1:0] iss_operand;

  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic [3:0]        rep_op_q, rep_op_d;
  logic [DATA_W-1:0] rep_operand_q, rep_operand_d;
  logic              done_q, done_d;
  logic [3:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_operand_q;
  logic              alu_en_q;

  assign bus.instr_ready_o = (level != FullLvl);
  assign push              = bus.instr_valid_i & bus.instr_ready_o;
  assign pop_op            = rd_word[InstrW-1 -: OPC_W];
  assign pop_operand       = rd_word[DATA_W-1:0];

  instr_fifo #(
    .Depth (DEPTH),
    .Width (InstrW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_n_i),
    .clr_i   (flush_i),
    .push_i  (push),
    .wdata_i ({bus.instr_opcode_i, bus.instr_operand_i}),
    .pop_i   (pop),
    .rdata_o (rd_word),
    .level_o (level),
    .empty_o (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next state and pop decision. IDLE pops directly when a word is present so a word
  // written on one edge can be popped on the very next one.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
    end else if (!hold_i) begin
      unique case (state_q)
        StIdle, StRun: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (is_issuable(pop_op) && (rep_cnt_q != '0)) state_d = StRepeat;
            else if ((level > LvlW'(1)) || push)          state_d = StRun;
            else                                          state_d = StIdle;
          end else begin
            state_d = StIdle;
          end
        end
        StRepeat: begin
          if (rep_cnt_q == REP_W'(1)) state_d = (!fifo_empty || push) ? StRun : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Issue selection, repeat counter and HALT pulse for the next edge.
  always_comb begin
    issue         = 1'b0;
    iss_op        = rep_op_q;
    iss_operand   = rep_operand_q;
    rep_cnt_d     = rep_cnt_q;
    rep_op_d      = rep_op_q;
    rep_operand_d = rep_operand_q;
    done_d        = 1'b0;
    if (flush_i) begin
      rep_cnt_d = '0;
    end else if (!hold_i) begin
      if (state_q == StRepeat) begin
        // Re-issue the latched word; the count here is the number of issues still owed.
        issue     = 1'b1;
        rep_cnt_d = rep_cnt_q - 1'b1;
      end else if (pop) begin
        if (is_issuable(pop_op)) begin
          issue         = 1'b1;
          iss_op        = pop_op;
          iss_operand   = pop_operand;
          rep_op_d      = pop_op;
          rep_operand_d = pop_operand;
        end else begin
          case (pop_op)
            OP_REPEAT: rep_cnt_d = pop_operand[REP_W-1:0];
            OP_HALT: begin
              done_d    = 1'b1;
              rep_cnt_d = '0;
            end
            default: ;  // NOP is dropped
          endcase
        end
      end
    end
  end

  // Registered outputs and repeat bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_cnt_q     <= '0;
      rep_op_q      <= IDLE_OPCODE;
      rep_operand_q <= '0;
      done_q        <= 1'b0;
      alu_opcode_q  <= IDLE_OPCODE;
      alu_operand_q <= '0;
      alu_en_q      <= 1'b0;
    end else begin
      rep_cnt_q     <= rep_cnt_d;
      rep_op_q      <= rep_op_d;
      rep_operand_q <= rep_operand_d;
      done_q        <= done_d;
      alu_opcode_q  <= issue ? iss_op : IDLE_OPCODE;
      alu_en_q      <= issue;
      if (issue) alu_operand_q <= iss_operand;
    end
  end

  assign bus.alu_opcode_o  = alu_opcode_q;
  assign bus.alu_operand_o = alu_operand_q;
  assign bus.alu_en_o      = alu_en_q;
  assign done_o            = done_q;
  assign fifo_level_o      = level;
  assign busy_o            = !fifo_empty || (rep_cnt_q != '0) || (state_q == StRepeat) || alu_en_q;

endmodule

// File: tb/tb_alu_instruction_sequencer.sv
// Directed scenarios for the instruction sequencer with hand-computed expectations.
module tb_alu_instruction_sequencer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REP_W  = 8;

  logic       clk;
  logic       rst_n;
  logic       hold;
  logic       flush;
  logic       busy;
  logic       done;
  logic [2:0] level;

  int n_checks;
  int n_fail;

  alu_instruction_sequencer_if #(.DATA_W(DATA_W)) bus ();

  alu_instruction_sequencer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REP_W  (REP_W)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .bus          (bus),
    .hold_i       (hold),
    .flush_i      (flush),
    .busy_o       (busy),
    .done_o       (done),
    .fifo_level_o (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] d);
    bus.instr_valid_i   = v;
    bus.instr_opcode_i  = op;
    bus.instr_operand_i = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    drive(1'b0, 4'h0, 16'h0);
    step();
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'hC) begin n_fail++; $display("FAIL reset_opcode: got %h expected c", bus.alu_opcode_o); end
    n_checks++; if (bus.alu_operand_o !== 16'h0) begin n_fail++; $display("FAIL reset_operand: got %h expected 0", bus.alu_operand_o); end
    n_checks++; if (bus.alu_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", bus.alu_en_o); end
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_done_busy: got %b%b expected 00", done, busy); end
    n_checks++; if (bus.instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready_o); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
  endtask

  task automatic test_single_issue();
    drive(1'b1, 4'h1, 16'hBEEF);
    step();  // accepted
    drive(1'b0, 4'h0, 16'h0);
    n_checks++; if (level !== 3'd1 || bus.alu_en_o !== 1'b0) begin n_fail++; $display("FAIL single_accept: got level %0d en %b expected 1 0", level, bus.alu_en_o); end
    step();  // popped and issued
    n_checks++; if (bus.alu_opcode_o !== 4'h1 || bus.alu_operand_o !== 16'hBEEF || bus.alu_en_o !== 1'b1) begin
      n_fail++; $display("FAIL single_issue: got %h/%h/%b expected 1/beef/1", bus.alu_opcode_o, bus.alu_operand_o, bus.alu_en_o);
    end
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'hC || bus.alu_en_o !== 1'b0 || bus.alu_operand_o !== 16'hBEEF) begin
      n_fail++; $display("FAIL single_idle: got %h/%h/%b expected c/beef/0", bus.alu_opcode_o, bus.alu_operand_o, bus.alu_en_o);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b expected 0", busy); end
  endtask

  task automatic test_repeat();
    drive(1'b1, 4'hD, 16'h0003);
    step();
    drive(1'b1, 4'h3, 16'h1234);
    step();  // REPEAT popped, not issued
    drive(1'b0, 4'h0, 16'h0);
    n_checks++; if (bus.alu_en_o !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL repeat_load: got en %b busy %b expected 0 1", bus.alu_en_o, busy); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (bus.alu_opcode_o !== 4'h3 || bus.alu_operand_o !== 16'h1234 || bus.alu_en_o !== 1'b1) begin
        n_fail++; $display("FAIL repeat_issue%0d: got %h/%h/%b expected 3/1234/1", i, bus.alu_opcode_o, bus.alu_operand_o, bus.alu_en_o);
      end
    end
    step();
    n_checks++; if (bus.alu_en_o !== 1'b0 || bus.alu_opcode_o !== 4'hC || busy !== 1'b0) begin
      n_fail++; $display("FAIL repeat_end: got en %b op %h busy %b expected 0 c 0", bus.alu_en_o, bus.alu_opcode_o, busy);
    end
  endtask

  task automatic test_hold_in_repeat();
    drive(1'b1, 4'hD, 16'h0002);
    step();
    drive(1'b1, 4'h9, 16'h0099);
    step();
    drive(1'b0, 4'h0, 16'h0);
    step();  // first issue
    n_checks++; if (bus.alu_opcode_o !== 4'h9 || bus.alu_en_o !== 1'b1) begin n_fail++; $display("FAIL hold_rep_first: got %h/%b expected 9/1", bus.alu_opcode_o, bus.alu_en_o); end
    hold = 1'b1;
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'hC || bus.alu_en_o !== 1'b0) begin n_fail++; $display("FAIL hold_rep_frozen: got %h/%b expected c/0", bus.alu_opcode_o, bus.alu_en_o); end
    hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++; if (bus.alu_opcode_o !== 4'h9 || bus.alu_en_o !== 1'b1) begin n_fail++; $display("FAIL hold_rep_resume%0d: got %h/%b expected 9/1", i, bus.alu_opcode_o, bus.alu_en_o); end
    end
    step();
    n_checks++; if (bus.alu_en_o !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_rep_end: got en %b busy %b expected 0 0", bus.alu_en_o, busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [4];
    ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h5; ops[3] = 4'hA;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], 16'h0100 + 16'(i));
      step();
    end
    n_checks++; if (level !== 3'd4 || bus.instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_full: got level %0d ready %b expected 4 0", level, bus.instr_ready_o); end
    n_checks++; if (bus.alu_en_o !== 1'b0) begin n_fail++; $display("FAIL fill_no_issue: got %b expected 0", bus.alu_en_o); end
    drive(1'b1, 4'h6, 16'hDEAD);  // offered while full, must be refused
    step();
    drive(1'b0, 4'h0, 16'h0);
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_overflow: got level %0d expected 4", level); end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (bus.alu_opcode_o !== ops[i] || bus.alu_operand_o !== (16'h0100 + 16'(i)) || bus.alu_en_o !== 1'b1) begin
        n_fail++; $display("FAIL b2b_issue%0d: got %h/%h/%b expected %h/%h/1", i, bus.alu_opcode_o, bus.alu_operand_o, bus.alu_en_o, ops[i], 16'h0100 + 16'(i));
      end
      if (i == 0) begin
        n_checks++; if (bus.instr_ready_o !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL b2b_ready: got ready %b level %0d expected 1 3", bus.instr_ready_o, level); end
      end
    end
    step();
    n_checks++; if (bus.alu_en_o !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL b2b_drain: got en %b level %0d expected 0 0", bus.alu_en_o, level); end
  endtask

  task automatic test_halt_nop();
    drive(1'b1, 4'h8, 16'h0008);
    step();
    drive(1'b1, 4'hF, 16'h000F);
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'h8 || bus.alu_en_o !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL halt_seq_op8: got %h/%b done %b expected 8/1 0", bus.alu_opcode_o, bus.alu_en_o, done); end
    drive(1'b1, 4'hE, 16'h000E);
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'hC || bus.alu_en_o !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL halt_seq_nop: got %h/%b done %b expected c/0 0", bus.alu_opcode_o, bus.alu_en_o, done); end
    drive(1'b1, 4'h7, 16'h0007);
    step();
    n_checks++; if (done !== 1'b1 || bus.alu_en_o !== 1'b0) begin n_fail++; $display("FAIL halt_seq_done: got done %b en %b expected 1 0", done, bus.alu_en_o); end
    drive(1'b0, 4'h0, 16'h0);
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'h7 || bus.alu_en_o !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL halt_seq_op7: got %h/%b done %b expected 7/1 0", bus.alu_opcode_o, bus.alu_en_o, done); end
    step();
    n_checks++; if (bus.alu_en_o !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL halt_seq_end: got en %b done %b expected 0 0", bus.alu_en_o, done); end
  endtask

  task automatic test_flush();
    int issues;
    drive(1'b1, 4'hD, 16'h0005);
    step();
    drive(1'b1, 4'h4, 16'hABCD);
    step();
    drive(1'b0, 4'h0, 16'h0);
    step();
    step();
    n_checks++; if (bus.alu_opcode_o !== 4'h4 || bus.alu_en_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %h/%b expected 4/1", bus.alu_opcode_o, bus.alu_en_o); end
    flush = 1'b1;
    hold  = 1'b1;
    drive(1'b1, 4'h6, 16'h0606);  // dropped by the flush
    step();
    flush = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 4'h0, 16'h0);
    n_checks++; if (bus.alu_en_o !== 1'b0 || bus.alu_opcode_o !== 4'hC || level !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL flush_state: got en %b op %h level %0d busy %b done %b expected 0 c 0 0 0", bus.alu_en_o, bus.alu_opcode_o, level, busy, done);
    end
    issues = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.alu_en_o === 1'b1) issues++;
    end
    n_checks++; if (issues !== 0) begin n_fail++; $display("FAIL flush_no_reissue: got %0d issues expected 0", issues); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'h1, 16'h1111);
    step();
    drive(1'b1, 4'h2, 16'h2222);
    step();
    drive(1'b1, 4'h3, 16'h3333);
    step();
    drive(1'b0, 4'h0, 16'h0);
    n_checks++; if (bus.alu_opcode_o !== 4'h2 || bus.alu_en_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got %h/%b expected 2/1", bus.alu_opcode_o, bus.alu_en_o); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.alu_opcode_o !== 4'hC || bus.alu_en_o !== 1'b0 || level !== 3'd0) begin
      n_fail++; $display("FAIL arst_immediate: got %h/%b level %0d expected c/0 0", bus.alu_opcode_o, bus.alu_en_o, level);
    end
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++; if (level !== 3'd0 || bus.instr_ready_o !== 1'b1 || busy !== 1'b0 || bus.alu_en_o !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL arst_after: got level %0d ready %b busy %b en %b done %b expected 0 1 0 0 0", level, bus.instr_ready_o, busy, bus.alu_en_o, done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_issue();
    test_repeat();
    test_hold_in_repeat();
    test_back_to_back();
    test_halt_nop();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
